s3g_host_link: RTL
==================

// Module: s3g_host_link
// PURPOSE
//  Host-side S3G link stage. It sits directly upstream of the uart_transceiver TX path
//  that feeds mojo_top's s3g_rx, and downstream of its RX path.
//  It frames a buffered payload as D5,len,payload,crc8 and streams it byte-by-byte.
//  It then hunts, buffers and CRC-checks the reply packet, with a response timeout.
//  Used by benches and by a future on-board loopback/self-test controller.
// PARAMETERS
//  MAX_PAYLOAD     32      payload bytes held per direction (1..255)
//  ADDR_W          5       buffer index width; 2**ADDR_W >= MAX_PAYLOAD
//  TIMEOUT_CYCLES  200000  clk cycles from last TX byte done to complete reply
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  pl_data      in   8       payload byte to append
//  pl_wr        in   1       append pl_data (ignored when busy or full)
//  pl_count     out  8       bytes currently buffered for TX
//  pl_ovf       out  1       sticky: pl_wr while full; cleared by send
//  send         in   1       pulse: transmit buffered frame
//  busy         out  1       TX in progress or reply pending
//  tx_data      out  8       byte to uart_transceiver
//  tx_wr        out  1       1-cycle write strobe
//  tx_done      in   1       uart byte-complete pulse
//  rx_data      in   8       byte from uart_transceiver
//  rx_done      in   1       uart byte-received pulse
//  rsp_addr     in   ADDR_W  reply buffer read index
//  rsp_rdata    out  8       reply byte at rsp_addr, registered (1-cycle latency)
//  rsp_len      out  8       reply payload length, valid from rsp_valid
//  rsp_valid    out  1       1-cycle pulse: reply complete
//  rsp_crc_err  out  1       qualifies rsp_valid: received crc != computed
//  rsp_timeout  out  1       1-cycle pulse: no complete reply in TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset: all outputs 0; TX FSM=T_IDLE; RX FSM=R_HUNT; buffers' count=0; timer stopped.
//  TX FSM: T_IDLE -> T_START -> T_LEN -> T_DATA (x pl_count) -> T_CRC -> T_IDLE.
//   - Each state issues tx_wr for exactly one cycle on entry, then waits for tx_done.
//   - Advance to the next byte on the cycle after tx_done.
//   - The first tx_wr is asserted in the cycle after send is sampled.
//   - Bytes: 8'hD5, pl_count, payload[0..n-1], crc8 over the payload only.
//   - CRC is updated as each payload byte is issued.
//  send is ignored when busy or pl_count==0.
//  On send, pl_ovf is cleared and the reply buffer is invalidated (rsp_len keeps its old value).
//  After the CRC byte's tx_done: pl_count<=0, the timer is armed, and RX is forced to R_HUNT.
//  busy stays high until rsp_valid or rsp_timeout.
//  RX FSM: R_HUNT -> R_LEN -> R_DATA -> R_CRC -> R_HUNT. It advances only on rx_done.
//   - R_HUNT: any byte other than 8'hD5 is discarded.
//   - R_LEN: len==0 or len>MAX_PAYLOAD returns to R_HUNT with no pulse.
//     Otherwise the len is latched into rsp_len and the RX crc8 is cleared.
//   - R_DATA: bytes are stored at index 0..len-1 and fed to the RX crc8.
//   - R_CRC: pulse rsp_valid; rsp_crc_err = (rx_data != crc). Return to R_HUNT.
//  Unsolicited replies (timer not armed) are still parsed and reported.
//  Timer: counts while armed and reloads on every rx_done.
//   - At TIMEOUT_CYCLES it pulses rsp_timeout, disarms, forces R_HUNT and drops busy.
//   - rx_done in the expiry cycle wins: the timer reloads and no timeout pulse is issued.
//   - rsp_valid disarms the timer.
//  A pl_wr in the same cycle as send is ignored.
//  pl_wr while full sets pl_ovf and does not modify the buffer.
//  Asynchronous reset mid-frame: tx_wr drops immediately and everything returns to its reset state.
//  The partial frame is abandoned; it is the DUT's job to discard it.
// STRUCTURE
//  Shared s3g package constants: S3G_START=8'hD5, S3G_MAX_PAYLOAD.
//  Shared s3g package typedefs: tx_state_t, rx_state_t.
//  Two instances of the existing crc8 module (TX and RX), each cleared at frame start.
//  Buffers are two small dp_ram instances, or register arrays if MAX_PAYLOAD<=16.
//  No further sub-module is needed.
// TESTING
//  1 load 80 81 00, send -> tx bytes D5 03 80 81 00 crc; exactly one tx_wr per tx_done; pl_count->0
//  2 feed D5 05 80 81 81 BA CE 64 -> rsp_valid, rsp_len=5, rsp_crc_err=0; rsp_addr 0..4 reads 80 81 81 BA CE
//  3 feed 00 12 then D5 03 23 45 81 C6 -> noise is discarded; rsp_valid, len 3, crc_err 0
//  4 corrupt last byte to 65 in scenario 2 -> rsp_valid with rsp_crc_err=1; also D5 00 gives no pulse
//  5 send with no reply -> rsp_timeout exactly TIMEOUT_CYCLES after the last tx_done; busy drops
//  6 33 pl_wr -> pl_count=32, pl_ovf=1; a send during busy is ignored; rst_n low mid-payload -> tx_wr=0 at once, busy=0

Source files
------------

// File: rtl/s3g_host_link_pkg.sv
// Shared S3G framing constants, FSM state types and the byte-wise CRC-8 step.
// The CRC is the reflected 0x31 polynomial (0x8C shifted right), zero initial value.
package s3g_host_link_pkg;

    localparam logic [7:0] S3G_START       = 8'hD5;
    localparam int         S3G_MAX_PAYLOAD = 32;

    typedef enum logic [2:0] {
        T_IDLE  = 3'd0,
        T_START = 3'd1,
        T_LEN   = 3'd2,
        T_DATA  = 3'd3,
        T_CRC   = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        R_HUNT = 2'd0,
        R_LEN  = 2'd1,
        R_DATA = 2'd2,
        R_CRC  = 2'd3
    } rx_state_t;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/s3g_host_link_crc8.sv
// Running CRC-8 accumulator: synchronous clear at frame start, one byte per enable.
module s3g_host_link_crc8
    import s3g_host_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    logic [7:0] crc_r;

    // CRC accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= 8'h00;
        end else if (clr) begin
            crc_r <= 8'h00;
        end else if (en) begin
            crc_r <= crc8_step(crc_r, din);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/s3g_host_link.sv
// Host-side S3G link: frames the TX payload as D5,len,payload,crc8 and
// hunts/buffers/checks the reply with a response timeout.
module s3g_host_link
    import s3g_host_link_pkg::*;
#(
    parameter int MAX_PAYLOAD    = S3G_MAX_PAYLOAD,
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        pl_data,
    input  logic              pl_wr,
    output logic [7:0]        pl_count,
    output logic              pl_ovf,
    input  logic              send,
    output logic              busy,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_done,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic [ADDR_W-1:0] rsp_addr,
    output logic [7:0]        rsp_rdata,
    output logic [7:0]        rsp_len,
    output logic              rsp_valid,
    output logic              rsp_crc_err,
    output logic              rsp_timeout
);

    localparam int            DEPTH    = 1 << ADDR_W;
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    MAX_LEN  = 8'(MAX_PAYLOAD);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    tx_state_t     tx_state_r;
    rx_state_t     rx_state_r;
    logic [7:0]    tx_buf [0:DEPTH-1];
    logic [7:0]    rx_buf [0:DEPTH-1];
    logic [7:0]    pl_count_r, tx_idx_r, rx_idx_r, tx_data_r, rsp_len_r, rsp_rdata_r;
    logic          pl_ovf_r, busy_r, tx_wr_r, rsp_valid_r, rsp_crc_err_r, rsp_timeout_r;
    logic          rsp_ok_r, armed_r;
    logic [TW-1:0] timer_r;
    logic [7:0]    tx_crc_s, rx_crc_s, tx_byte_s;
    logic          send_ok_s, pl_wr_ok_s, tx_end_s, tx_crc_en_s, tmo_s;
    logic          rx_frame_s, rx_len_ok_s, rx_crc_en_s;

    // Acceptance and event decode shared by the TX, buffer and RX/timer blocks
    always_comb begin
        send_ok_s   = send && !busy_r && (pl_count_r != 8'd0);
        pl_wr_ok_s  = pl_wr && !send && !busy_r && (pl_count_r != MAX_LEN);
        tx_end_s    = (tx_state_r == T_CRC) && tx_done;
        tx_byte_s   = tx_buf[tx_idx_r[ADDR_W-1:0]];
        tmo_s       = armed_r && !rx_done && (timer_r == TMO_LAST);
        rx_frame_s  = rx_done && (rx_state_r == R_CRC) && !tx_end_s;
        rx_len_ok_s = rx_done && (rx_state_r == R_LEN) && !tx_end_s &&
                      (rx_data != 8'd0) && (rx_data <= MAX_LEN);
        rx_crc_en_s = rx_done && (rx_state_r == R_DATA) && !tx_end_s;
        if (tx_done && ((tx_state_r == T_LEN) ||
                        ((tx_state_r == T_DATA) && (tx_idx_r != pl_count_r)))) begin
            tx_crc_en_s = 1'b1;
        end else begin
            tx_crc_en_s = 1'b0;
        end
    end

    s3g_host_link_crc8 u_tx_crc (
        .clk(clk), .rst_n(rst_n), .clr(send_ok_s), .en(tx_crc_en_s),
        .din(tx_byte_s), .crc(tx_crc_s)
    );

    s3g_host_link_crc8 u_rx_crc (
        .clk(clk), .rst_n(rst_n), .clr(rx_len_ok_s), .en(rx_crc_en_s),
        .din(rx_data), .crc(rx_crc_s)
    );

    // TX payload buffer
    always_ff @(posedge clk) begin
        if (pl_wr_ok_s) begin
            tx_buf[pl_count_r[ADDR_W-1:0]] <= pl_data;
        end
    end

    // Reply payload buffer
    always_ff @(posedge clk) begin
        if (rx_crc_en_s) begin
            rx_buf[rx_idx_r[ADDR_W-1:0]] <= rx_data;
        end
    end

    // TX framing FSM: one tx_wr on entry to each byte state, advance after tx_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= T_IDLE;
            tx_wr_r    <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_idx_r   <= 8'd0;
        end else begin
            tx_wr_r <= 1'b0;
            case (tx_state_r)
                T_IDLE: begin
                    if (send_ok_s) begin
                        tx_state_r <= T_START;
                        tx_wr_r    <= 1'b1;
                        tx_data_r  <= S3G_START;
                        tx_idx_r   <= 8'd0;
                    end
                end
                T_START: begin
                    if (tx_done) begin
                        tx_state_r <= T_LEN;
                        tx_wr_r    <= 1'b1;
                        tx_data_r  <= pl_count_r;
                    end
                end
                T_LEN: begin
                    if (tx_done) begin
                        tx_state_r <= T_DATA;
                        tx_wr_r    <= 1'b1;
                        tx_data_r  <= tx_byte_s;
                        tx_idx_r   <= tx_idx_r + 8'd1;
                    end
                end
                T_DATA: begin
                    if (tx_done) begin
                        tx_wr_r <= 1'b1;
                        if (tx_idx_r == pl_count_r) begin
                            tx_state_r <= T_CRC;
                            tx_data_r  <= tx_crc_s;
                        end else begin
                            tx_data_r <= tx_byte_s;
                            tx_idx_r  <= tx_idx_r + 8'd1;
                        end
                    end
                end
                T_CRC: begin
                    if (tx_done) begin
                        tx_state_r <= T_IDLE;
                    end
                end
                default: begin
                    tx_state_r <= T_IDLE;
                end
            endcase
        end
    end

    // Payload count, overflow flag and busy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_count_r <= 8'd0;
            pl_ovf_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            if (tx_end_s) begin
                pl_count_r <= 8'd0;
            end else if (pl_wr_ok_s) begin
                pl_count_r <= pl_count_r + 8'd1;
            end
            if (send_ok_s) begin
                pl_ovf_r <= 1'b0;
            end else if (pl_wr && !send && (pl_count_r == MAX_LEN)) begin
                pl_ovf_r <= 1'b1;
            end
            if (send_ok_s) begin
                busy_r <= 1'b1;
            end else if (armed_r && (tmo_s || rx_frame_s)) begin
                busy_r <= 1'b0;
            end
        end
    end

    // Reply parser and response timer; end of TX and expiry both re-hunt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r    <= R_HUNT;
            rx_idx_r      <= 8'd0;
            rsp_len_r     <= 8'd0;
            rsp_valid_r   <= 1'b0;
            rsp_crc_err_r <= 1'b0;
            rsp_timeout_r <= 1'b0;
            rsp_ok_r      <= 1'b0;
            armed_r       <= 1'b0;
            timer_r       <= '0;
        end else begin
            rsp_valid_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
            if (tx_end_s) begin
                armed_r    <= 1'b1;
                timer_r    <= '0;
                rx_state_r <= R_HUNT;
            end else if (tmo_s) begin
                armed_r       <= 1'b0;
                rsp_timeout_r <= 1'b1;
                rx_state_r    <= R_HUNT;
            end else begin
                if (armed_r) begin
                    timer_r <= rx_done ? '0 : timer_r + TW'(1);
                end
                if (rx_done) begin
                    case (rx_state_r)
                        R_HUNT: begin
                            if (rx_data == S3G_START) begin
                                rx_state_r <= R_LEN;
                            end
                        end
                        R_LEN: begin
                            if (rx_len_ok_s) begin
                                rx_state_r <= R_DATA;
                                rsp_len_r  <= rx_data;
                                rx_idx_r   <= 8'd0;
                                rsp_ok_r   <= 1'b0;
                            end else begin
                                rx_state_r <= R_HUNT;
                            end
                        end
                        R_DATA: begin
                            rx_idx_r <= rx_idx_r + 8'd1;
                            if (rx_idx_r == (rsp_len_r - 8'd1)) begin
                                rx_state_r <= R_CRC;
                            end
                        end
                        R_CRC: begin
                            rsp_valid_r   <= 1'b1;
                            rsp_crc_err_r <= (rx_data != rx_crc_s);
                            rsp_ok_r      <= 1'b1;
                            armed_r       <= 1'b0;
                            rx_state_r    <= R_HUNT;
                        end
                        default: begin
                            rx_state_r <= R_HUNT;
                        end
                    endcase
                end
            end
            if (send_ok_s) begin
                rsp_ok_r <= 1'b0;
            end
        end
    end

    // Registered reply read port; reads 0 while the buffer is invalidated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_r <= 8'h00;
        end else if (rsp_ok_r) begin
            rsp_rdata_r <= rx_buf[rsp_addr];
        end else begin
            rsp_rdata_r <= 8'h00;
        end
    end

    assign pl_count    = pl_count_r;
    assign pl_ovf      = pl_ovf_r;
    assign busy        = busy_r;
    assign tx_data     = tx_data_r;
    assign tx_wr       = tx_wr_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_len     = rsp_len_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_crc_err = rsp_crc_err_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule
